// File: rtl/cmos_line_packer_if.sv
// cmos_line_packer_if: camera stream in, forwarded bytes and line/frame status out
// master: drives the camera stream and fifo_full, observes outputs
// slave:  the packer side
interface cmos_line_packer_if;
  logic        vin_vsync;
  logic        vin_href;
  logic [7:0]  vin_data;
  logic        fifo_full;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic        line_done;
  logic [15:0] line_frame_id;
  logic [15:0] line_id;
  logic [11:0] line_len;
  logic        line_ok;
  logic        frame_done;
  logic [7:0]  err_cnt;
  logic        busy;
  modport master (
    output vin_vsync, vin_href, vin_data, fifo_full,
    input  dout_valid, dout_data, line_done, line_frame_id, line_id, line_len, line_ok,
           frame_done, err_cnt, busy
  );
  modport slave (
    input  vin_vsync, vin_href, vin_data, fifo_full,
    output dout_valid, dout_data, line_done, line_frame_id, line_id, line_len, line_ok,
           frame_done, err_cnt, busy
  );
endinterface

// File: rtl/cmos_line_packer.sv
// cmos_line_packer: frames a registered CMOS byte stream into forwarded bytes plus per-line descriptors
// pclk/rst: clock and synchronous active-high reset
// bus.vin_*: camera vsync/href/data; bus.fifo_full: downstream backpressure
// bus.dout_*: forwarded bytes (1-cycle latency); bus.line_*: descriptor held until next line_done
// bus.frame_done: end-of-frame pulse; bus.err_cnt: saturating error count; bus.busy: line in progress
module cmos_line_packer #(
  parameter int H_BYTES = 1280,
  parameter int V_LINES = 480,
  parameter bit VS_POL  = 1
) (
  input logic              pclk,
  input logic              rst,
  cmos_line_packer_if.slave bus
);
  typedef enum logic [2:0] {WAIT_VS, WAIT_LINE, IN_LINE, DROP_LINE, LINE_END} state_t;
  localparam logic [11:0] HB = 12'(H_BYTES);
  localparam logic [15:0] VL = 16'(V_LINES);
  state_t      state_q, state_d;
  logic        vs_q, href_q, bad_q, bad_d;
  logic [11:0] cnt_q, cnt_d, llen_q;
  logic [15:0] line_q, line_d, frame_q, frame_d, lfid_q, lid_q;
  logic [7:0]  err_q, dd_q;
  logic        dv_q, ld_q, lok_q, fd_q;
  logic        vs_edge, rise, fall, ok, take, fwd, emit, emit_ok, err_inc, fdone;
  assign vs_edge = VS_POL ? (bus.vin_vsync & ~vs_q) : (~bus.vin_vsync & vs_q);
  assign rise    = bus.vin_href & ~href_q;
  assign fall    = ~bus.vin_href & href_q;
  // bad_q marks a fifo drop, whose error is already counted; length errors are counted at line end
  assign ok      = cnt_q == HB && !bad_q;
  // the opening href edge already carries the first byte of the line
  assign take    = bus.vin_href & (state_q == IN_LINE | (state_q == WAIT_LINE & rise & line_q < VL));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    frame_d = frame_q;
    bad_d   = bad_q;
    fwd     = 1'b0;
    emit    = 1'b0;
    emit_ok = 1'b0;
    err_inc = 1'b0;
    fdone   = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_edge) begin
        state_d = WAIT_LINE;
        line_d  = '0;
      end
      WAIT_LINE: if (rise && line_q >= VL) begin
        state_d = DROP_LINE;
        err_inc = 1'b1;
      end
      IN_LINE:   if (fall) state_d = LINE_END;
      // lines beyond V_LINES stay dropped until the frame ends, so they cost one error in total
      DROP_LINE: if (fall && line_q < VL) state_d = LINE_END;
      LINE_END: begin
        emit    = 1'b1;
        emit_ok = ok;
        err_inc = !ok && !bad_q;
        line_d  = line_q + 16'd1;
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = WAIT_LINE;
      end
      default: state_d = WAIT_VS;
    endcase
    if (take) begin
      if (bus.fifo_full) begin
        state_d = DROP_LINE;
        bad_d   = 1'b1;
        err_inc = 1'b1;
      end else begin
        state_d = IN_LINE;
        fwd     = cnt_q < HB;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 12'd1;
      end
    end
    // a frame edge overrides everything; a line still open or just finishing is reported first
    if (vs_edge && state_q != WAIT_VS) begin
      emit    = state_q inside {IN_LINE, LINE_END};
      emit_ok = state_q == LINE_END && ok;
      err_inc = state_q == IN_LINE || (state_q == LINE_END && !ok && !bad_q);
      fwd     = 1'b0;
      fdone   = line_q != '0 || state_q == LINE_END;
      frame_d = frame_q + 16'd1;
      line_d  = '0;
      cnt_d   = '0;
      bad_d   = 1'b0;
      state_d = WAIT_LINE;
    end
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= WAIT_VS;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
      frame_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= '0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
      lfid_q  <= '0;
      lid_q   <= '0;
      llen_q  <= '0;
      lok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.vin_vsync;
      href_q  <= bus.vin_href;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      bad_q   <= bad_d;
      err_q   <= err_q + 8'(err_inc && err_q != 8'hFF);
      dv_q    <= fwd;
      dd_q    <= fwd ? bus.vin_data : dd_q;
      ld_q    <= emit;
      fd_q    <= fdone;
      lfid_q  <= emit ? frame_q : lfid_q;
      lid_q   <= emit ? line_q : lid_q;
      llen_q  <= emit ? cnt_q : llen_q;
      lok_q   <= emit ? emit_ok : lok_q;
    end
  end
  assign bus.dout_valid    = dv_q;
  assign bus.dout_data     = dd_q;
  assign bus.line_done     = ld_q;
  assign bus.line_frame_id = lfid_q;
  assign bus.line_id       = lid_q;
  assign bus.line_len      = llen_q;
  assign bus.line_ok       = lok_q;
  assign bus.frame_done    = fd_q;
  assign bus.err_cnt       = err_q;
  assign bus.busy          = state_q inside {IN_LINE, DROP_LINE, LINE_END};
endmodule

// File: tb/tb_cmos_line_packer.sv
// tb_cmos_line_packer: directed line/frame vectors against default, V_LINES=4 and VS_POL=0 instances
module tb_cmos_line_packer;
  logic       pclk = 0, rst = 1, vsync = 0, href = 0, full = 0;
  logic [7:0] data = 0, pd = 0;
  int errors = 0, checks = 0;
  int dvc[3] = '{0, 0, 0};
  int ldc[3] = '{0, 0, 0};
  int fdc = 0, fwd0 = 0, lastfwd = 0, dmis = 0, both0 = 0;
  always #5 pclk = ~pclk;
  cmos_line_packer_if i0 (), i1 (), i2 ();
  assign i0.vin_vsync = vsync;  assign i0.vin_href = href; assign i0.vin_data = data; assign i0.fifo_full = full;
  assign i1.vin_vsync = vsync;  assign i1.vin_href = href; assign i1.vin_data = data; assign i1.fifo_full = full;
  assign i2.vin_vsync = ~vsync; assign i2.vin_href = href; assign i2.vin_data = data; assign i2.fifo_full = full;
  cmos_line_packer u0 (.pclk(pclk), .rst(rst), .bus(i0.slave));
  cmos_line_packer #(.V_LINES(4)) u1 (.pclk(pclk), .rst(rst), .bus(i1.slave));
  cmos_line_packer #(.VS_POL(0)) u2 (.pclk(pclk), .rst(rst), .bus(i2.slave));
  always @(posedge pclk) pd <= data;
  always @(negedge pclk) begin
    dvc[0] <= dvc[0] + int'(i0.dout_valid);
    dvc[1] <= dvc[1] + int'(i1.dout_valid);
    dvc[2] <= dvc[2] + int'(i2.dout_valid);
    ldc[0] <= ldc[0] + int'(i0.line_done);
    ldc[1] <= ldc[1] + int'(i1.line_done);
    ldc[2] <= ldc[2] + int'(i2.line_done);
    fdc    <= fdc + int'(i0.frame_done);
    fwd0   <= (i0.line_done || rst) ? 0 : fwd0 + int'(i0.dout_valid);
    if (i0.line_done) lastfwd <= fwd0 + int'(i0.dout_valid);
    if (i0.dout_valid && (i0.dout_data != pd || i0.dout_data != fwd0[7:0])) dmis <= dmis + 1;
    if (i0.dout_valid && i0.line_done) both0 <= both0 + 1;
  end
  typedef struct {
    int nb; int full_at; bit abort;
    int frame; int line; int len; bit ok; int fwd; int err; int fd;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask
  task automatic send_line(input int nb, input int full_at, input bit abort);
    for (int b = 0; b < nb; b++) begin
      step(1);
      href = 1;
      data = 8'(b);
      full = full_at >= 0 && b >= full_at;
    end
    step(1);
    full = 0;
    if (abort) begin
      vsync = 1;
      data  = 8'(nb);
      step(1);
    end
    href = 0;
    step(3);
    vsync = 0;
    step(8);
  endtask
  task automatic pulse_vs();
    step(1);
    vsync = 1;
    step(3);
    vsync = 0;
    step(5);
  endtask
  task automatic run_vec(input int i);
    int l0, f0;
    l0 = ldc[0];
    f0 = fdc;
    send_line(v[i].nb, v[i].full_at, v[i].abort);
    chk($sformatf("v%0d line_done_count", i), ldc[0] - l0, 1);
    chk($sformatf("v%0d line_frame_id", i), i0.line_frame_id, v[i].frame);
    chk($sformatf("v%0d line_id", i), i0.line_id, v[i].line);
    chk($sformatf("v%0d line_len", i), i0.line_len, v[i].len);
    chk($sformatf("v%0d line_ok", i), i0.line_ok, v[i].ok);
    chk($sformatf("v%0d forwarded", i), lastfwd, v[i].fwd);
    chk($sformatf("v%0d err_cnt", i), i0.err_cnt, v[i].err);
    chk($sformatf("v%0d frame_done_count", i), fdc - f0, v[i].fd);
  endtask
  initial begin
    int l, d, f;
    for (int i = 0; i < 5; i++) v[i] = '{1280, -1, 0, 0, i, 1280, 1, 1280, 0, 0};
    v[5]  = '{700,  -1,  1, 0, 5, 700,  0, 700,  1, 1};
    v[6]  = '{1000, -1,  0, 1, 0, 1000, 0, 1000, 2, 0};
    v[7]  = '{1300, -1,  0, 1, 1, 1300, 0, 1280, 3, 0};
    v[8]  = '{1280, 500, 0, 1, 2, 500,  0, 500,  4, 0};
    v[9]  = '{1280, -1,  0, 1, 3, 1280, 1, 1280, 4, 0};
    v[10] = '{1280, -1,  0, 2, 0, 1280, 1, 1280, 4, 0};
    step(3);
    chk("rst dout_valid", i0.dout_valid, 0);
    chk("rst dout_data", i0.dout_data, 0);
    chk("rst line_done", i0.line_done, 0);
    chk("rst frame_done", i0.frame_done, 0);
    chk("rst line_len", i0.line_len, 0);
    chk("rst err_cnt", i0.err_cnt, 0);
    chk("rst busy", i0.busy, 0);
    rst = 0;
    step(2);
    send_line(100, -1, 0);
    chk("pre_vsync dv u0", dvc[0], 0);
    chk("pre_vsync dv u1", dvc[1], 0);
    chk("pre_vsync dv u2", dvc[2], 0);
    chk("pre_vsync line_done", ldc[0], 0);
    pulse_vs();
    for (int i = 0; i < 10; i++) begin
      run_vec(i);
      if (i == 5) begin
        chk("vlines4 line_done_count", ldc[1], 4);
        chk("vlines4 err_cnt", i1.err_cnt, 1);
        chk("vlines4 forwarded", dvc[1], 5120);
      end
    end
    f = fdc;
    pulse_vs();
    chk("idle vsync frame_done", fdc - f, 1);
    chk("idle busy", i0.busy, 0);
    run_vec(10);
    chk("u0 total dv", dvc[0], 12440);
    chk("u0 total line_done", ldc[0], 11);
    chk("u1 total dv", dvc[1], 10460);
    chk("u1 total line_done", ldc[1], 9);
    chk("u1 err_cnt", i1.err_cnt, 4);
    chk("u2 total dv", dvc[2], 12440);
    chk("u2 total line_done", ldc[2], 11);
    chk("u2 err_cnt", i2.err_cnt, 4);
    chk("u2 line_frame_id", i2.line_frame_id, 2);
    l = ldc[0];
    for (int b = 0; b < 300; b++) begin
      step(1);
      href = 1;
      data = 8'(b);
    end
    chk("midline busy", i0.busy, 1);
    rst = 1;
    step(2);
    chk("midrst line_frame_id", i0.line_frame_id, 0);
    chk("midrst line_id", i0.line_id, 0);
    chk("midrst line_ok", i0.line_ok, 0);
    chk("midrst err_cnt", i0.err_cnt, 0);
    chk("midrst busy", i0.busy, 0);
    rst = 0;
    d = dvc[0];
    for (int b = 302; b < 800; b++) begin
      step(1);
      data = 8'(b);
    end
    step(1);
    href = 0;
    step(8);
    send_line(1280, -1, 0);
    chk("after_rst dv", dvc[0] - d, 0);
    chk("after_rst line_done", ldc[0] - l, 0);
    f = fdc;
    pulse_vs();
    chk("first vsync frame_done", fdc - f, 0);
    send_line(1280, -1, 0);
    chk("post line_frame_id", i0.line_frame_id, 0);
    chk("post line_id", i0.line_id, 0);
    chk("post line_len", i0.line_len, 1280);
    chk("post line_ok", i0.line_ok, 1);
    chk("post forwarded", lastfwd, 1280);
    chk("post err_cnt", i0.err_cnt, 0);
    chk("post u2 line_ok", i2.line_ok, 1);
    chk("data latency/value", dmis, 0);
    chk("dv with line_done", both0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
